// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the uart_rx_stream receiver:
//   state_e    receiver frame-tracking states
//   parity_e   encoding of the cfg_parity input
//   TUSER_*    bit positions inside m_tuser
//   OVERSAMPLE oversampling ratio and the tick positions used inside a bit
//   majority3  2-of-3 vote helper
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int OS_WIDTH      = $clog2(OVERSAMPLE);
    localparam int SAMPLE_A_TICK = 7;
    localparam int SAMPLE_B_TICK = 8;
    localparam int VOTE_TICK     = 9;
    localparam int BIT_END_TICK  = OVERSAMPLE - 1;

    localparam int TUSER_PERR = 0;
    localparam int TUSER_FERR = 1;
    localparam int TUSER_BRK  = 2;

    // One FIFO word: {tuser[2:0], tdata[7:0]}
    localparam int RX_WORD_WIDTH = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRKWAIT
    } state_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'd0,
        PAR_ODD      = 2'd1,
        PAR_EVEN     = 2'd2,
        PAR_NONE_ALT = 2'd3
    } parity_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_buf
// Synchronous show-ahead FIFO. The head word is presented combinationally
// whenever the FIFO is non-empty (forced to zero when empty).
// Ports:
//   ACLK, ARESETn  clock, synchronous active-low reset
//   push           write request; accepted when not full, or when full and a
//                  pop happens in the same cycle
//   push_data      word to write
//   ready          consumer accepts head (pop when valid && ready)
//   valid          FIFO non-empty
//   head           word at the read pointer
//   count          entries held, 0..DEPTH
//   overflow       a push was rejected this cycle (full, no concurrent pop)
// -----------------------------------------------------------------------------
module uart_rx_fifo_buf #(
    parameter int WIDTH     = 11,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 ready,
    output logic                 valid,
    output logic [WIDTH-1:0]     head,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 wr_en;

    assign empty    = (count == '0);
    assign full     = (count == CNT_WIDTH'(DEPTH));
    assign pop      = !empty && ready;
    // When full, the concurrent pop frees the slot the write lands in.
    assign wr_en    = push && (!full || pop);
    assign overflow = push && full && !pop;

    assign valid = !empty;
    assign head  = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define which
    // entries are meaningful, and head is masked while empty.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// -----------------------------------------------------------------------------
// uart_rx_stream
// 16x oversampling UART receiver with 2-of-3 majority voting, runtime frame
// format, parity/framing/break/overrun detection and a show-ahead receive FIFO
// presented as a valid/ready stream.
// Ports:
//   ACLK, ARESETn   clock, synchronous active-low reset
//   srx             asynchronous serial input, idle high
//   cfg_en          receiver enable (0 aborts any frame in progress)
//   cfg_div         ACLK cycles per 1/16 bit (0 behaves as 1)
//   cfg_width       0..3 -> 5..8 data bits
//   cfg_parity      0/3 none, 1 odd, 2 even
//   cfg_stop        0 one stop bit, 1 two stop bits
//   m_tvalid/m_tready/m_tdata/m_tuser  receive stream (tuser = {brk, ferr, perr})
//   fifo_count      entries held in the FIFO
//   overrun         sticky character-dropped flag, cleared by overrun_clr
// -----------------------------------------------------------------------------
module uart_rx_stream
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 srx,
    input  logic                 cfg_en,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [1:0]           cfg_width,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop,
    output logic                 m_tvalid,
    output logic [7:0]           m_tdata,
    output logic [2:0]           m_tuser,
    input  logic                 m_tready,
    output logic [CNT_WIDTH-1:0] fifo_count,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    logic                     sync1;
    logic                     sync2;
    logic                     sync_prev;
    logic                     fall;

    logic [DIV_WIDTH-1:0]     div_cnt;
    logic [DIV_WIDTH-1:0]     div_reload;
    logic                     tick;
    logic [OS_WIDTH-1:0]      os_cnt;
    logic                     samp_a;
    logic                     samp_b;
    logic                     vote;
    logic                     vote_tick;
    logic                     bit_end;

    state_e                   state_q;
    state_e                   state_d;
    logic                     frame_start;

    logic [1:0]               lat_width;
    parity_e                  lat_parity;
    logic                     lat_stop;
    logic                     par_en;
    logic [2:0]               last_idx;

    logic [7:0]               data_q;
    logic [2:0]               bit_idx;
    logic                     perr_q;
    logic                     ferr_q;
    logic                     brk_q;
    logic                     par_bit_q;
    logic                     brk_now;

    logic                     push;
    logic [RX_WORD_WIDTH-1:0] push_word;
    logic [RX_WORD_WIDTH-1:0] head;
    logic                     fifo_overflow;

    assign fall        = sync_prev && !sync2;
    assign div_reload  = (cfg_div == '0) ? '0 : cfg_div - DIV_WIDTH'(1);
    assign tick        = (state_q != IDLE) && (div_cnt == '0);
    assign vote_tick   = tick && (os_cnt == OS_WIDTH'(VOTE_TICK));
    assign bit_end     = tick && (os_cnt == OS_WIDTH'(BIT_END_TICK));
    assign vote        = majority3(samp_a, samp_b, sync2);
    assign par_en      = (lat_parity == PAR_ODD) || (lat_parity == PAR_EVEN);
    assign last_idx    = 3'(lat_width) + 3'd4;
    assign frame_start = (state_q == IDLE) && (state_d == START);
    // Unused data bits stay zero from frame start, so a whole-byte compare works.
    assign brk_now     = (data_q == '0) && !par_bit_q && !vote;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge value of its sources.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and push generation. Pushing at the stop-bit vote leaves the
    // second half of the stop bit for catching the next start edge.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d   = state_q;
        push      = 1'b0;
        push_word = '0;
        if (!cfg_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (vote_tick && vote) begin
                        state_d = IDLE;
                    end else if (bit_end) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (bit_end && (bit_idx == last_idx)) begin
                        state_d = par_en ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_d = STOP1;
                    end
                end
                STOP1: begin
                    if (vote_tick && !lat_stop) begin
                        push                       = 1'b1;
                        push_word[7:0]             = data_q;
                        push_word[8 + TUSER_PERR]  = perr_q;
                        push_word[8 + TUSER_FERR]  = !vote;
                        push_word[8 + TUSER_BRK]   = brk_now;
                        state_d                    = brk_now ? BRKWAIT : IDLE;
                    end else if (bit_end) begin
                        state_d = STOP2;
                    end
                end
                STOP2: begin
                    if (vote_tick) begin
                        push                       = 1'b1;
                        push_word[7:0]             = data_q;
                        push_word[8 + TUSER_PERR]  = perr_q;
                        push_word[8 + TUSER_FERR]  = ferr_q || !vote;
                        push_word[8 + TUSER_BRK]   = brk_q;
                        state_d                    = brk_q ? BRKWAIT : IDLE;
                    end
                end
                BRKWAIT: begin
                    if (sync2) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Synchronizer, oversample timing and frame datapath.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync_prev  <= 1'b1;
            div_cnt    <= '0;
            os_cnt     <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            lat_width  <= 2'd3;
            lat_parity <= PAR_NONE;
            lat_stop   <= 1'b0;
            data_q     <= '0;
            bit_idx    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            sync1     <= srx;
            sync2     <= sync1;
            sync_prev <= sync2;

            // Held in reload while idle so the first tick lands a full
            // divisor period after the start edge.
            if (state_q == IDLE || div_cnt == '0) begin
                div_cnt <= div_reload;
            end else begin
                div_cnt <= div_cnt - DIV_WIDTH'(1);
            end

            if (state_q == IDLE) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= os_cnt + OS_WIDTH'(1);
            end

            if (tick && os_cnt == OS_WIDTH'(SAMPLE_A_TICK)) begin
                samp_a <= sync2;
            end
            if (tick && os_cnt == OS_WIDTH'(SAMPLE_B_TICK)) begin
                samp_b <= sync2;
            end

            if (frame_start) begin
                lat_width  <= cfg_width;
                lat_parity <= parity_e'(cfg_parity);
                lat_stop   <= cfg_stop;
                data_q     <= '0;
                bit_idx    <= '0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
                brk_q      <= 1'b0;
                par_bit_q  <= 1'b0;
            end

            if (state_q == DATA) begin
                if (vote_tick) begin
                    data_q[bit_idx] <= vote;
                end
                if (bit_end) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end

            if (state_q == PARITY && vote_tick) begin
                par_bit_q <= vote;
                // XOR over data and parity bit is 1 when the total ones count is odd.
                perr_q    <= (lat_parity == PAR_ODD) ? !(^{data_q, vote}) : (^{data_q, vote});
            end

            if (state_q == STOP1 && vote_tick) begin
                ferr_q <= !vote;
                brk_q  <= brk_now;
            end
        end
    end

    uart_rx_fifo_buf #(
        .WIDTH     (RX_WORD_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .push      (push),
        .push_data (push_word),
        .ready     (m_tready),
        .valid     (m_tvalid),
        .head      (head),
        .count     (fifo_count),
        .overflow  (fifo_overflow)
    );

    assign m_tdata = head[7:0];
    assign m_tuser = head[RX_WORD_WIDTH-1:8];

    // A new drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            overrun <= 1'b0;
        end else if (fifo_overflow) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_stream
// Self-checking bench for uart_rx_stream (FIFO_DEPTH=4, cfg_div=4).
// Frames are serialised bit by bit; every expected character is queued when
// its frame is driven and compared when the stream port hands it over.
// -----------------------------------------------------------------------------
module tb_uart_rx_stream;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int DIV     = 4;
    localparam int BIT_CYC = 16 * DIV;

    logic             ACLK;
    logic             ARESETn;
    logic             srx;
    logic             cfg_en;
    logic [15:0]      cfg_div;
    logic [1:0]       cfg_width;
    logic [1:0]       cfg_parity;
    logic             cfg_stop;
    logic             m_tvalid;
    logic [7:0]       m_tdata;
    logic [2:0]       m_tuser;
    logic             m_tready;
    logic [CNT_W-1:0] fifo_count;
    logic             overrun;
    logic             overrun_clr;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic [1:0] width;
        logic [1:0] parity;
        logic       stop;
        logic       bad_par;
        logic       bad_stop;
        logic [7:0] exp_data;
        logic [2:0] exp_user;
    } vec_t;

    vec_t vecs [9];

    uart_rx_stream #(
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (16),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .srx         (srx),
        .cfg_en      (cfg_en),
        .cfg_div     (cfg_div),
        .cfg_width   (cfg_width),
        .cfg_parity  (cfg_parity),
        .cfg_stop    (cfg_stop),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tuser     (m_tuser),
        .m_tready    (m_tready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] w, input logic [1:0] p);
        logic [7:0] mask;
        logic       odd_ones;
        mask     = 8'hFF >> (3 - int'(w));
        odd_ones = ^(d & mask);
        return (p == 2'd1) ? ~odd_ones : odd_ones;
    endfunction

    // Serialises one frame starting at the next clock edge. pop_at >= 0 pulses
    // m_tready so a pop lands on that edge (counted from the start-bit edge);
    // probe checks m_tvalid shortly before and after the final stop-bit vote.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic [1:0] p,
                              input logic s, input logic bad_par, input logic bad_stop,
                              input int pop_at, input bit probe);
        logic bits [12];
        int   n;
        int   nb;
        nb         = 5 + int'(w);
        cfg_width  = w;
        cfg_parity = p;
        cfg_stop   = s;
        bits[0]    = 1'b0;
        for (int i = 0; i < nb; i++) bits[1 + i] = d[i];
        n = 1 + nb;
        if (p == 2'd1 || p == 2'd2) begin
            bits[n] = parity_bit(d, w, p) ^ bad_par;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (s) begin
            bits[n] = 1'b1;
            n++;
        end
        bits[n - 1] = bits[n - 1] ^ bad_stop;
        for (int c = 0; c < n * BIT_CYC; c++) begin
            @(posedge ACLK);
            #1;
            srx = bits[c / BIT_CYC];
            if (pop_at >= 0) m_tready = (c == pop_at - 1);
            if (probe && c == (n - 1) * BIT_CYC + 30) check("valid_before_push", 32'(m_tvalid), 0);
            if (probe && c == (n - 1) * BIT_CYC + 50) check("valid_after_push", 32'(m_tvalid), 1);
        end
        if (pop_at >= 0) m_tready = 1'b0;
    endtask

    task automatic expect_char(input logic [2:0] u, input logic [7:0] d);
        exp_q.push_back({u, d});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETn && m_tvalid && m_tready) begin
                check("char_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("rx_char", {m_tuser, m_tdata}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h41, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 8'h41, 3'b001};
        vecs[1] = '{8'h41, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 8'h41, 3'b000};
        vecs[2] = '{8'h3F, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h1F, 3'b000};
        vecs[3] = '{8'h2A, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h2A, 3'b000};
        vecs[4] = '{8'h96, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0, 8'h96, 3'b000};
        vecs[5] = '{8'h00, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};
        vecs[6] = '{8'hFF, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 8'hFF, 3'b000};
        vecs[7] = '{8'h80, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};
        vecs[8] = '{8'h5A, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 8'h5A, 3'b010};

        ARESETn     = 1'b0;
        srx         = 1'b1;
        cfg_en      = 1'b1;
        cfg_div     = 16'(DIV);
        cfg_width   = 2'd3;
        cfg_parity  = 2'd0;
        cfg_stop    = 1'b0;
        m_tready    = 1'b0;
        overrun_clr = 1'b0;
        idle(5);
        ARESETn = 1'b1;
        idle(2);

        check("reset_tvalid", 32'(m_tvalid), 0);
        check("reset_tdata", 32'(m_tdata), 0);
        check("reset_tuser", 32'(m_tuser), 0);
        check("reset_count", 32'(fifo_count), 0);
        check("reset_overrun", 32'(overrun), 0);

        // Back-to-back 8N1 frames held in the FIFO, then drained in order.
        expect_char(3'b000, 8'h55);
        send_frame(8'h55, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        expect_char(3'b000, 8'hA3);
        send_frame(8'hA3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        check("b2b_count", 32'(fifo_count), 2);
        m_tready = 1'b1;
        wait_drain("b2b_drain", 20);

        // Format / parity / framing table.
        for (int i = 0; i < 9; i++) begin
            expect_char(vecs[i].exp_user, vecs[i].exp_data);
            send_frame(vecs[i].data, vecs[i].width, vecs[i].parity, vecs[i].stop,
                       vecs[i].bad_par, vecs[i].bad_stop, -1, 1'b0);
            srx = 1'b1;
            idle(BIT_CYC);
            wait_drain("table_drain", 20);
        end

        // Start glitch shorter than half a bit: nothing received.
        m_tready   = 1'b0;
        cfg_width  = 2'd3;
        cfg_parity = 2'd0;
        cfg_stop   = 1'b0;
        srx        = 1'b0;
        idle(6 * DIV);
        srx = 1'b1;
        idle(2 * BIT_CYC);
        check("glitch_count", 32'(fifo_count), 0);
        expect_char(3'b000, 8'h7E);
        send_frame(8'h7E, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        check("after_glitch_count", 32'(fifo_count), 1);
        m_tready = 1'b1;
        wait_drain("glitch_drain", 20);

        // Break: line low for 20 bit times yields exactly one break entry.
        expect_char(3'b110, 8'h00);
        srx = 1'b0;
        idle(20 * BIT_CYC);
        srx = 1'b1;
        idle(2 * BIT_CYC);
        wait_drain("break_drain", 20);
        expect_char(3'b000, 8'h31);
        send_frame(8'h31, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        wait_drain("post_break_drain", 20);

        // Overrun: five characters into a four-entry FIFO with no consumer.
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_char(3'b000, 8'hA0 + 8'(i));
            send_frame(8'hA0 + 8'(i), 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        end
        check("full_count", 32'(fifo_count), 4);
        check("overrun_set", 32'(overrun), 1);
        overrun_clr = 1'b1;
        idle(1);
        overrun_clr = 1'b0;
        check("overrun_cleared", 32'(overrun), 0);
        // 8N1 push lands 619 edges after the start-bit edge; pop on that edge.
        expect_char(3'b000, 8'hA5);
        send_frame(8'hA5, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 619, 1'b0);
        check("full_pushpop_overrun", 32'(overrun), 0);
        check("full_pushpop_count", 32'(fifo_count), 4);
        m_tready = 1'b1;
        wait_drain("overrun_drain", 20);

        // Reset in the middle of data bit 3 with one character buffered.
        m_tready = 1'b0;
        send_frame(8'h12, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        check("pre_reset_count", 32'(fifo_count), 1);
        srx = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 3; i++) begin
            srx = i[0];
            idle(BIT_CYC);
        end
        srx = 1'b0;
        idle(BIT_CYC / 2);
        ARESETn = 1'b0;
        srx     = 1'b1;
        idle(1);
        ARESETn = 1'b1;
        check("midreset_tvalid", 32'(m_tvalid), 0);
        check("midreset_tdata", 32'(m_tdata), 0);
        check("midreset_tuser", 32'(m_tuser), 0);
        check("midreset_count", 32'(fifo_count), 0);
        idle(2 * BIT_CYC);
        m_tready = 1'b1;
        expect_char(3'b000, 8'hC8);
        send_frame(8'hC8, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        wait_drain("post_reset_drain", 20);

        idle(BIT_CYC);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_count", 32'(fifo_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
Synthesizable, parametrised UART receiver for the uart_axi_lite IP. It samples the serial line at 16x oversampling with majority voting. Character width, parity and stop bits are runtime-configurable, and framing, parity, break and overrun errors are all detected. Received characters are buffered in a FIFO and presented on an AXI-Stream-style valid/ready port for the register block.

Parameters:
FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256
DIV_WIDTH, 16, width of oversample-tick divisor
CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived)

Ports:
ACLK  input  1  system clock
ARESETn  input  1  reset, synchronous, active-low
srx  input  1  asynchronous serial input, idle high
cfg_en  input  1  receiver enable
cfg_div  input  DIV_WIDTH  ACLK cycles per 1/16 bit; 0 treated as 1
cfg_width  input  2  0=5,1=6,2=7,3=8 data bits
cfg_parity  input  2  0=none,1=odd,2=even,3=none
cfg_stop  input  1  0=1 stop bit, 1=2 stop bits
m_tvalid  output  1  FIFO head valid
m_tdata  output  8  received character, right-justified, unused MSBs zero
m_tuser  output  3  [0]=parity err,[1]=framing err,[2]=break
m_tready  input  1  consumer accepts head
fifo_count  output  CNT_WIDTH  entries held
overrun  output  1  sticky: a character was dropped
overrun_clr  input  1  clears overrun

Behaviour:
- Reset (ARESETn low at ACLK edge): m_tvalid=0, m_tdata=0, m_tuser=0, fifo_count=0, overrun=0, state IDLE. Both synchronizer flops preset to 1. Reset mid-frame discards the partial frame.
- srx passes through a 2-flop synchronizer.
- Tick generator: down-counter reloads to cfg_div-1 and emits a 1-cycle tick at 0. It is held in reload while in IDLE.
- os_cnt runs 0..15 on ticks. Samples are taken at os_cnt 7, 8 and 9; vote = majority, evaluated on the os_cnt=9 tick. The bit ends on the os_cnt=15 tick.
- cfg_width, cfg_parity and cfg_stop are latched on leaving IDLE; changes mid-frame have no effect.
- States:
  - IDLE: on synced falling edge (prev 1, now 0) with cfg_en=1 -> START, os_cnt=0.
  - START: vote=1 -> IDLE (glitch, no push). Otherwise at bit end -> DATA.
  - DATA: vote shifted in LSB-first; after the latched width -> PARITY if parity enabled, else STOP1.
  - PARITY: parity err = XOR(data, vote) mismatches odd/even rule.
  - STOP1: at vote, framing err = !vote. With 2 stop bits, -> STOP2 at bit end. Otherwise push and -> IDLE, or -> BRKWAIT on break.
  - STOP2: vote=0 also sets framing err; push at vote.
  - BRKWAIT: wait for synced srx=1, then -> IDLE.
- Pushing at mid-stop allows back-to-back frames with no lost start edge.
- Break = all data bits 0, parity bit 0 (if present) and stop vote 0. Break also sets framing err.
- cfg_en=0: FSM forced to IDLE next edge, no push. FIFO contents and read port are unaffected.
- FIFO is show-ahead: m_tdata/m_tuser reflect the head. m_tvalid = count!=0. Pop on m_tvalid&&m_tready.
- Push is visible one cycle later (m_tvalid, fifo_count registered).
- Push when full: accepted if a pop occurs the same cycle. Otherwise the character is dropped and overrun is set.
- Simultaneous push and pop at non-full, non-empty: count unchanged. Push at empty with m_tready=1: no pop that cycle.
- Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
- overrun_clr and a new overrun event in the same cycle: set wins.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT), parity enum, TUSER_PERR/TUSER_FERR/TUSER_BRK bit indices, OVERSAMPLE=16.
- Sub-module uart_rx_fifo_buf: synchronous show-ahead FIFO, width 11, depth FIFO_DEPTH, with count output.

Test Plan:
- 8N1, cfg_div=4, send 0x55 then 0xA3 back-to-back -> two entries in order, tuser=0, m_tvalid rises 1 cycle after each mid-stop push.
- 7E1, send 0x41 with parity bit forced wrong -> tdata 0x41, tuser=3'b001; then 7O1 correct -> tuser 0.
- Glitch: srx low for 6 ticks, then high -> no entry, FSM back to IDLE, next valid 0x7E received.
- Break: srx low 20 bit times -> exactly one entry, tdata 0x00, tuser=3'b110; nothing more until line high and a new 0x31 frame arrives.
- FIFO_DEPTH=4, m_tready=0, send 5 characters -> fifo_count=4, overrun=1, 5th lost. overrun_clr -> 0. Full push with concurrent pop -> no overrun.
- ARESETn low during DATA bit 3 -> all outputs reset next edge; following 0xC8 8O2 frame received with tuser=0.
